// File: rtl/expander_input_poller_pkg.sv
// Shared constants for the GPIO expander poller and the power/config sequencer.
package expander_input_poller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_PTR = 3'd1,
    ST_RD_LO  = 3'd2,
    ST_RD_HI  = 3'd3,
    ST_UPDATE = 3'd4,
    ST_ERR    = 3'd5
  } poll_state_e;

  localparam logic [7:0] EXP_ADDRESS = 8'h25;

  localparam logic [7:0] INPUT0  = 8'h00;
  localparam logic [7:0] INPUT1  = 8'h01;
  localparam logic [7:0] OUTPUT0 = 8'h02;
  localparam logic [7:0] OUTPUT1 = 8'h03;
  localparam logic [7:0] CONFIG0 = 8'h06;
  localparam logic [7:0] CONFIG1 = 8'h07;

  function automatic logic [7:0] addr_byte(input logic [7:0] addr, input logic rd);
    return {addr[7:1], rd};
  endfunction

  function automatic int tick_period(input int clk_rate, input int poll_rate);
    int p;
    p = (poll_rate > 0) ? clk_rate / poll_rate : 1;
    return (p < 1) ? 1 : p;
  endfunction

endpackage

// File: rtl/expander_input_poller_tick_gen.sv
// Poll-rate divider: one-cycle tick every PERIOD cycles while enabled.
module poll_tick_gen #(
  parameter int PERIOD = 48000
) (
  input  logic clk48_i,
  input  logic reset_n_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  assign wrap   = (cnt_q == CNT_W'(PERIOD - 1));
  assign tick_o = enable_i & wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (!enable_i)  cnt_d = '0;
    else if (wrap)  cnt_d = '0;
    else            cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk48_i or negedge reset_n_i) begin
    if (!reset_n_i) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

endmodule

// File: rtl/expander_input_poller.sv
// Polls the 16-bit input port of the I2C GPIO expander through i2c_master.
// Optional debounce filter: EXPANDER_POLLER_DEBOUNCE_EN.
module expander_input_poller
  import expander_input_poller_pkg::*;
#(
  parameter int INPUT_CLK_RATE = 48000000,
  parameter int POLL_RATE_HZ   = 1000,
`ifdef EXPANDER_POLLER_DEBOUNCE_EN
  parameter int DEBOUNCE_SAMPLES = 3,
`endif
  parameter logic [7:0] ADDRESS   = EXP_ADDRESS,
  parameter logic [7:0] INPUT_REG = INPUT0
) (
  input  logic        clk48,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        poll_req,
  input  logic        transfer_ready,
  input  logic        interrupt,
  input  logic        nack,
  input  logic        address_err,
  input  logic [7:0]  data_rx,
  output logic        transfer_start,
  output logic        transfer_continues,
  output logic [7:0]  address,
  output logic [7:0]  data_tx,
  output logic [15:0] port_value,
  output logic        value_valid,
  output logic        changed,
  output logic        busy,
  output logic        nack_err
);

  localparam int PERIOD = tick_period(INPUT_CLK_RATE, POLL_RATE_HZ);
  localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  poll_state_e      state_q, state_d;
  logic             pending_q, pending_d;
  logic             start_q, start_d;
  logic             cont_q, cont_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       dtx_q, dtx_d;
  logic [7:0]       lo_q, lo_d;
  logic [7:0]       hi_q, hi_d;
  logic [15:0]      port_q, port_d;
  logic             valid_q, valid_d;
  logic             changed_q, changed_d;
  logic             busy_q, busy_d;
  logic             nerr_q, nerr_d;
  logic [CNT_W-1:0] errcnt_q, errcnt_d;
  logic             tick;
  logic             fail;
  logic             accept;
  logic [15:0]      rd_val;

`ifdef EXPANDER_POLLER_DEBOUNCE_EN
  logic [15:0] cand_q, cand_d;
  logic [1:0]  dbcnt_q, dbcnt_d;
`endif

  poll_tick_gen #(.PERIOD(PERIOD)) u_tick (
    .clk48_i   (clk48),
    .reset_n_i (reset_n),
    .enable_i  (enable),
    .tick_o    (tick)
  );

  assign rd_val = {hi_q, lo_q};

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | tick | poll_req;
    start_d   = start_q;
    cont_d    = cont_q;
    addr_d    = addr_q;
    dtx_d     = dtx_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    port_d    = port_q;
    valid_d   = valid_q;
    changed_d = 1'b0;
    busy_d    = busy_q;
    nerr_d    = nerr_q;
    errcnt_d  = errcnt_q;
    fail      = 1'b0;
    accept    = 1'b0;
`ifdef EXPANDER_POLLER_DEBOUNCE_EN
    cand_d    = cand_q;
    dbcnt_d   = dbcnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pending_q && transfer_ready) begin
          start_d   = 1'b1;
          cont_d    = 1'b1;
          addr_d    = addr_byte(ADDRESS, 1'b0);
          dtx_d     = INPUT_REG;
          busy_d    = 1'b1;
          pending_d = tick | poll_req;
          state_d   = ST_WR_PTR;
        end
      end
      ST_WR_PTR: begin
        if (interrupt) begin
          if (address_err || nack) begin
            fail = 1'b1;
          end else begin
            start_d = 1'b1;
            cont_d  = 1'b1;
            addr_d  = addr_byte(ADDRESS, 1'b1);
            state_d = ST_RD_LO;
          end
        end
      end
      ST_RD_LO: begin
        if (interrupt) begin
          if (address_err) begin
            fail = 1'b1;
          end else begin
            // dropping both strobes makes the master NACK+STOP the high byte
            lo_d    = data_rx;
            start_d = 1'b0;
            cont_d  = 1'b0;
            state_d = ST_RD_HI;
          end
        end
      end
      ST_RD_HI: begin
        if (interrupt) begin
          if (address_err) begin
            fail = 1'b1;
          end else begin
            hi_d    = data_rx;
            state_d = ST_UPDATE;
          end
        end
      end
      ST_UPDATE: begin
`ifdef EXPANDER_POLLER_DEBOUNCE_EN
        if (rd_val == cand_q && dbcnt_q != 2'd0) begin
          dbcnt_d = (dbcnt_q == 2'd3) ? 2'd3 : dbcnt_q + 2'd1;
        end else begin
          cand_d  = rd_val;
          dbcnt_d = 2'd1;
        end
        accept = (int'(dbcnt_d) >= DEBOUNCE_SAMPLES);
`else
        accept = 1'b1;
`endif
        if (accept) begin
          port_d    = rd_val;
          valid_d   = 1'b1;
          changed_d = (rd_val != port_q) || !valid_q;
        end
        nerr_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (errcnt_q == '0) state_d = ST_IDLE;
        else                errcnt_d = errcnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // back off for one full poll period before retrying
    if (fail) begin
      start_d  = 1'b0;
      cont_d   = 1'b0;
      nerr_d   = 1'b1;
      busy_d   = 1'b0;
      errcnt_d = CNT_W'(PERIOD - 1);
      state_d  = ST_ERR;
    end
  end

  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      start_q   <= 1'b0;
      cont_q    <= 1'b0;
      addr_q    <= addr_byte(ADDRESS, 1'b0);
      dtx_q     <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      port_q    <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      busy_q    <= 1'b0;
      nerr_q    <= 1'b0;
      errcnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      start_q   <= start_d;
      cont_q    <= cont_d;
      addr_q    <= addr_d;
      dtx_q     <= dtx_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      port_q    <= port_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      busy_q    <= busy_d;
      nerr_q    <= nerr_d;
      errcnt_q  <= errcnt_d;
    end
  end

`ifdef EXPANDER_POLLER_DEBOUNCE_EN
  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) begin
      cand_q  <= '0;
      dbcnt_q <= '0;
    end else begin
      cand_q  <= cand_d;
      dbcnt_q <= dbcnt_d;
    end
  end
`endif

  assign transfer_start     = start_q;
  assign transfer_continues = cont_q;
  assign address            = addr_q;
  assign data_tx            = dtx_q;
  assign port_value         = port_q;
  assign value_valid        = valid_q;
  assign changed            = changed_q;
  assign busy               = busy_q;
  assign nack_err           = nerr_q;

endmodule

// File: tb/tb_expander_input_poller.sv
// Directed bench for expander_input_poller with a behavioural i2c_master stand-in.
module tb_expander_input_poller;

  logic        clk48 = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        poll_req = 1'b0;
  logic        transfer_ready = 1'b1;
  logic        interrupt = 1'b0;
  logic        nack = 1'b0;
  logic        address_err = 1'b0;
  logic [7:0]  data_rx = 8'h00;
  logic        transfer_start, transfer_continues;
  logic [7:0]  address, data_tx;
  logic [15:0] port_value;
  logic        value_valid, changed, busy, nack_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    int          err;      // 0 none, 1 address_err on WR_PTR, 2 nack on WR_PTR, 3 nack on last read byte
    logic [15:0] exp_port;
    logic        exp_valid;
    logic        exp_nerr;
    int          exp_chg;
  } vec_t;

  vec_t vec [7];

  expander_input_poller #(.INPUT_CLK_RATE(100000), .POLL_RATE_HZ(1000)) dut (
    .clk48              (clk48),
    .reset_n            (reset_n),
    .enable             (enable),
    .poll_req           (poll_req),
    .transfer_ready     (transfer_ready),
    .interrupt          (interrupt),
    .nack               (nack),
    .address_err        (address_err),
    .data_rx            (data_rx),
    .transfer_start     (transfer_start),
    .transfer_continues (transfer_continues),
    .address            (address),
    .data_tx            (data_tx),
    .port_value         (port_value),
    .value_valid        (value_valid),
    .changed            (changed),
    .busy               (busy),
    .nack_err           (nack_err)
  );

  always #5 clk48 = ~clk48;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_int(input logic [7:0] d, input logic aerr, input logic nk);
    interrupt = 1'b1; data_rx = d; address_err = aerr; nack = nk;
    @(negedge clk48);
    interrupt = 1'b0; address_err = 1'b0; nack = 1'b0;
  endtask

  // Waits for a launch and plays the master side of one poll transaction.
  task automatic serve(input logic [7:0] lo, input logic [7:0] hi, input int err,
                       input int preq, output int nchg);
    int w;
    nchg = 0;
    w = 0;
    while (!transfer_start && w < 400) begin
      @(negedge clk48);
      w++;
    end
    chk("start_seen", 32'(transfer_start), 1);
    if (!transfer_start) return;
    chk("wr_addr", 32'(address), 32'h24);
    chk("wr_ptr", 32'(data_tx), 32'h00);
    chk("busy_on", 32'(busy), 1);
    transfer_ready = 1'b0;
    repeat (2) @(negedge clk48);
    for (int i = 0; i < preq; i++) begin
      poll_req = 1'b1;
      @(negedge clk48);
      poll_req = 1'b0;
      @(negedge clk48);
    end
    chk("start_hold", 32'(transfer_start), 1);
    pulse_int(8'h00, err == 1, err == 2);
    if (err == 1 || err == 2) begin
      chk("err_start", 32'(transfer_start), 0);
      chk("err_busy", 32'(busy), 0);
      transfer_ready = 1'b1;
      return;
    end
    chk("rd_addr", 32'(address), 32'h25);
    chk("rep_start", 32'({transfer_start, transfer_continues}), 32'h3);
    repeat (2) @(negedge clk48);
    pulse_int(lo, 1'b0, 1'b0);
    chk("last_strobes", 32'({transfer_start, transfer_continues}), 32'h0);
    repeat (2) @(negedge clk48);
    pulse_int(hi, 1'b0, err == 3);
    repeat (3) begin
      if (changed) nchg++;
      @(negedge clk48);
    end
    chk("busy_off", 32'(busy), 0);
    transfer_ready = 1'b1;
  endtask

  initial begin
    int nchg;
    int bad;
    int w;

    vec[0] = '{8'h5A, 8'hA5, 0, 16'hA55A, 1'b1, 1'b0, 1};
    vec[1] = '{8'h5A, 8'hA5, 0, 16'hA55A, 1'b1, 1'b0, 0};
    vec[2] = '{8'h5B, 8'hA5, 0, 16'hA55B, 1'b1, 1'b0, 1};
    vec[3] = '{8'h11, 8'h22, 1, 16'hA55B, 1'b1, 1'b1, 0};
    vec[4] = '{8'h34, 8'h12, 0, 16'h1234, 1'b1, 1'b0, 1};
    vec[5] = '{8'h00, 8'h00, 2, 16'h1234, 1'b1, 1'b1, 0};
    vec[6] = '{8'h56, 8'h78, 3, 16'h7856, 1'b1, 1'b0, 1};

    repeat (3) @(negedge clk48);
    chk("rst_strobes", 32'({transfer_start, transfer_continues}), 0);
    chk("rst_addr", 32'(address), 32'h24);
    chk("rst_port", 32'(port_value), 0);
    chk("rst_flags", 32'({value_valid, changed, busy, nack_err}), 0);
    reset_n = 1'b1;

    // Tick arrives while the master is not ready; launch must follow ready within a cycle.
    enable = 1'b1;
    transfer_ready = 1'b0;
    repeat (150) @(negedge clk48);
    chk("no_start_unready", 32'(transfer_start), 0);
    transfer_ready = 1'b1;
    @(negedge clk48);
    chk("launch_latency", 32'(transfer_start), 1);

`ifdef EXPANDER_POLLER_DEBOUNCE_EN
    begin
      logic [7:0]  db_lo [5];
      logic [15:0] db_exp [5];
      db_lo  = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h02};
      db_exp = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0002};
      for (int i = 0; i < 5; i++) begin
        serve(db_lo[i], 8'h00, 0, 0, nchg);
        chk($sformatf("db_port[%0d]", i), 32'(port_value), 32'(db_exp[i]));
        chk($sformatf("db_valid[%0d]", i), 32'(value_valid), (i == 4) ? 1 : 0);
        chk($sformatf("db_chg[%0d]", i), nchg, (i == 4) ? 1 : 0);
      end
    end
`else
    for (int i = 0; i < 7; i++) begin
      serve(vec[i].lo, vec[i].hi, vec[i].err, 0, nchg);
      chk($sformatf("port[%0d]", i), 32'(port_value), 32'(vec[i].exp_port));
      chk($sformatf("valid[%0d]", i), 32'(value_valid), 32'(vec[i].exp_valid));
      chk($sformatf("nack_err[%0d]", i), 32'(nack_err), 32'(vec[i].exp_nerr));
      chk($sformatf("changed[%0d]", i), nchg, vec[i].exp_chg);
      if (vec[i].err == 1 || vec[i].err == 2) begin
        bad = 0;
        repeat (100) begin
          @(negedge clk48);
          if (transfer_start) bad++;
        end
        chk($sformatf("err_backoff[%0d]", i), bad, 0);
      end
    end
`endif

    enable = 1'b0;
    repeat (30) @(negedge clk48);
    if (transfer_start) serve(8'h56, 8'h78, 0, 0, nchg);

`ifndef EXPANDER_POLLER_DEBOUNCE_EN
    // Three manual requests during one transaction collapse into one follow-up.
    poll_req = 1'b1;
    @(negedge clk48);
    poll_req = 1'b0;
    serve(8'h01, 8'h02, 0, 3, nchg);
    chk("collapse_first", 32'(port_value), 32'h0201);
    serve(8'h03, 8'h04, 0, 0, nchg);
    chk("collapse_second", 32'(port_value), 32'h0403);
    bad = 0;
    repeat (300) begin
      @(negedge clk48);
      if (transfer_start) bad++;
    end
    chk("collapse_no_third", bad, 0);
`endif

    // Reset while in RD_LO must drop the strobes without waiting for a clock.
    poll_req = 1'b1;
    @(negedge clk48);
    poll_req = 1'b0;
    w = 0;
    while (!transfer_start && w < 20) begin
      @(negedge clk48);
      w++;
    end
    chk("rst_txn_start", 32'(transfer_start), 1);
    transfer_ready = 1'b0;
    repeat (2) @(negedge clk48);
    pulse_int(8'h00, 1'b0, 1'b0);
    chk("rd_lo_strobes", 32'({transfer_start, transfer_continues}), 32'h3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_strobes", 32'({transfer_start, transfer_continues}), 0);
    chk("async_rst_port", 32'(port_value), 0);
    chk("async_rst_valid", 32'(value_valid), 0);
    chk("async_rst_busy", 32'(busy), 0);
    @(negedge clk48);
    reset_n = 1'b1;
    transfer_ready = 1'b1;
    repeat (5) @(negedge clk48);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
